tap_decoder: RTL and testbench

TAP_DECODER -- requirements
Module: tap_decoder

---
 rtl/tap_decoder.sv | 100 ++++++++++
 tb/tb_tap_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tap_decoder.sv
// JTAG USER-register data decoder: RESULT_WIDTH-bit DR scan with readback capture,
// 8-bit write extraction on update_dr and a 2-entry output FIFO with sticky overflow.
module tap_decoder #(
  parameter int unsigned RESULT_WIDTH = 16
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    test_logic_reset,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic [RESULT_WIDTH-1:0] result,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  input  logic                    byte_ready,
  output logic                    overflow
);

  logic [RESULT_WIDTH-1:0] shift_q;
  logic [7:0]              cnt_q;
  logic [7:0]              mem_q [2];
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [1:0]              count_q;
  logic                    overflow_q;

  logic       push_req;
  logic       push;
  logic       pop;
  logic       full;
  logic [7:0] wr_byte;

  // A byte is only written when exactly eight bits were shifted since capture.
  assign push_req = ir_is_user && update_dr && (cnt_q == 8'd8);
  assign full     = (count_q == 2'd2);
  assign pop      = (count_q != 2'd0) && byte_ready;
  assign push     = push_req && (!full || pop);
  assign wr_byte  = shift_q[RESULT_WIDTH-1 -: 8];

  assign tdo        = shift_q[0];
  assign byte_valid = (count_q != 2'd0);
  assign byte_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow   = overflow_q;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      cnt_q      <= 8'd0;
      mem_q[0]   <= 8'h00;
      mem_q[1]   <= 8'h00;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else if (test_logic_reset) begin
      shift_q    <= '0;
      cnt_q      <= 8'd0;
      mem_q[0]   <= 8'h00;
      mem_q[1]   <= 8'h00;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (ir_is_user) begin
        if (capture_dr) begin
          shift_q <= result;
          cnt_q   <= 8'd0;
        end else if (shift_dr) begin
          shift_q <= {tdi, shift_q[RESULT_WIDTH-1:1]};
          if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      end

      if (push) begin
        mem_q[wr_ptr_q] <= wr_byte;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      if (push_req && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tap_decoder.sv
// Bench for tap_decoder: directed scenarios plus random DR traffic, all outputs compared
// every cycle against a queue-based reference model.
module tb_tap_decoder;

  localparam int W = 16;

  logic         tck = 1'b0;
  logic         rst_n = 1'b0;
  logic         tdi = 1'b0;
  logic         tlr = 1'b0;
  logic         ir = 1'b0;
  logic         cap = 1'b0;
  logic         sh = 1'b0;
  logic         upd = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] result = '0;
  logic         tdo;
  logic         bv;
  logic [7:0]   bd;
  logic         ov;

  tap_decoder #(.RESULT_WIDTH(W)) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tdi              (tdi),
    .tdo              (tdo),
    .test_logic_reset (tlr),
    .ir_is_user       (ir),
    .capture_dr       (cap),
    .shift_dr         (sh),
    .update_dr        (upd),
    .result           (result),
    .byte_valid       (bv),
    .byte_data        (bd),
    .byte_ready       (rdy),
    .overflow         (ov)
  );

  always #5 tck = ~tck;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the scan register as a number, the output stage as a byte queue.
  logic [W-1:0] m_sr;
  int           m_cnt;
  logic [7:0]   m_q[$];
  bit           m_ovf;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    m_sr  = '0;
    m_cnt = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endfunction

  // Next-edge state from the inputs currently applied.
  function automatic void model_step();
    logic [7:0] wbyte;
    bit         wr;
    if (tlr) begin
      model_reset();
      return;
    end
    wr    = ir && upd && (m_cnt == 8);
    wbyte = m_sr >> (W - 8);
    if (ir && cap) begin
      m_sr  = result;
      m_cnt = 0;
    end else if (ir && sh) begin
      m_sr = (m_sr >> 1) | (W'(tdi) << (W - 1));
      if (m_cnt < 255) m_cnt++;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (wr) begin
      if (m_q.size() < 2) m_q.push_back(wbyte);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void check_all();
    logic [7:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 8'h00;
    chk("tdo", 64'(tdo), 64'(m_sr[0]));
    chk("byte_valid", 64'(bv), 64'(m_q.size() > 0));
    chk("byte_data", 64'(bd), 64'(head));
    chk("overflow", 64'(ov), 64'(m_ovf));
  endfunction

  task automatic cycle(input bit c, input bit s, input bit u, input bit i, input bit t,
                       input bit d, input bit r, input logic [W-1:0] res);
    @(negedge tck);
    cap = c; sh = s; upd = u; ir = i; tlr = t; tdi = d; rdy = r; result = res;
    model_step();
    @(posedge tck);
    #1;
    check_all();
  endtask

  task automatic idle(input bit r);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, result);
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n, input bit i, input bit r);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, i, 1'b0, b[k], r, result);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit i, input bit r);
    cycle(1'b1, 1'b0, 1'b0, i, 1'b0, 1'b0, r, result);
    shift_bits(b, 8, i, r);
    cycle(1'b0, 1'b0, 1'b1, i, 1'b0, 1'b0, r, result);
  endtask

  logic [15:0] rb;
  int          act;

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge tck);
    rst_n = 1'b1;

    // Single byte write with downstream ready: visible for exactly one cycle.
    write_byte(8'h41, 1'b1, 1'b1);
    chk("wr41_valid", 64'(bv), 64'd1);
    chk("wr41_data", 64'(bd), 64'h41);
    idle(1'b1);
    chk("wr41_gone", 64'(bv), 64'd0);

    // Backpressure: third byte dropped, FIFO order kept, overflow sticky.
    write_byte(8'h0A, 1'b1, 1'b0);
    write_byte(8'h2E, 1'b1, 1'b0);
    write_byte(8'h40, 1'b1, 1'b0);
    chk("bp_head", 64'(bd), 64'h0A);
    chk("bp_ovf", 64'(ov), 64'd1);
    idle(1'b1);
    chk("bp_second", 64'(bd), 64'h2E);
    idle(1'b1);
    chk("bp_empty", 64'(bv), 64'd0);
    chk("bp_ovf_sticky", 64'(ov), 64'd1);

    // Readback of result, LSB first, with no byte produced on update.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    rb[0] = tdo;
    for (int k = 1; k < 16; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, result);
      rb[k] = tdo;
    end
    chk("readback", 64'(rb), 64'h1234);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, result);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, result);
    chk("readback_nobyte", 64'(bv), 64'd0);

    // Gating: fill FIFO, write with ir_is_user=0, then test-logic-reset clears all.
    write_byte(8'h11, 1'b1, 1'b0);
    write_byte(8'h22, 1'b1, 1'b0);
    write_byte(8'h33, 1'b1, 1'b0);
    write_byte(8'h55, 1'b0, 1'b0);
    chk("gate_head", 64'(bd), 64'h11);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, result);
    chk("tlr_empty", 64'(bv), 64'd0);
    chk("tlr_ovf", 64'(ov), 64'd0);

    // Abort: partial shift discarded by a fresh capture.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, result);
    shift_bits(8'hFF, 5, 1'b1, 1'b1);
    write_byte(8'h23, 1'b1, 1'b1);
    chk("abort_data", 64'(bd), 64'h23);
    idle(1'b1);
    chk("abort_single", 64'(bv), 64'd0);

    // Async reset between shift and update: nothing emitted afterwards.
    write_byte(8'h5A, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    shift_bits(8'h77, 8, 1'b1, 1'b0);
    @(negedge tck);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_tdo", 64'(tdo), 64'd0);
    chk("arst_valid", 64'(bv), 64'd0);
    chk("arst_data", 64'(bd), 64'd0);
    chk("arst_ovf", 64'(ov), 64'd0);
    @(negedge tck);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, result);
    chk("arst_noupd", 64'(bv), 64'd0);

    // Random traffic against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        write_byte(8'($urandom), ($urandom_range(7, 0) != 0), 1'($urandom));
      end else begin
        for (int k = 0; k < 6; k++) begin
          act = $urandom_range(4, 0);
          cycle(act == 1, act == 2, act == 3, ($urandom_range(7, 0) != 0),
                ($urandom_range(19, 0) == 0), 1'($urandom), 1'($urandom), W'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
